// File: rtl/branch_predict_unit_if.sv
// ----------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the IF-stage lookup, the ID/EX branch fields and the predictor's
// resolution/statistics outputs into one connection.
//   master : pipeline side. Drives the fetch PC and EX branch fields, and
//            receives the prediction, flush, redirect and statistics.
//   slave  : predictor side (branch_predict_unit).
// Signals:
//   if_pc_i            fetch PC
//   if_predict_taken_o prediction for if_pc_i
//   ex_branch_i        EX holds a conditional branch
//   ex_predict_taken_i prediction carried from fetch
//   ex_taken_i         actual branch outcome
//   ex_pc_i            PC of the branch in EX
//   ex_pc_otherwise_i  path not chosen at fetch
//   flush_o            misprediction flush
//   pc_redirect_o      redirect target, valid while flush_o=1
//   branch_cnt_o       resolved branches since reset
//   mispredict_cnt_o   mispredictions since reset
// ----------------------------------------------------------------------------
interface branch_predict_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      if_pc_i;
    logic             if_predict_taken_o;
    logic             ex_branch_i;
    logic             ex_predict_taken_i;
    logic             ex_taken_i;
    logic [31:0]      ex_pc_i;
    logic [31:0]      ex_pc_otherwise_i;
    logic             flush_o;
    logic [31:0]      pc_redirect_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    modport master (
        output if_pc_i,
        output ex_branch_i,
        output ex_predict_taken_i,
        output ex_taken_i,
        output ex_pc_i,
        output ex_pc_otherwise_i,
        input  if_predict_taken_o,
        input  flush_o,
        input  pc_redirect_o,
        input  branch_cnt_o,
        input  mispredict_cnt_o
    );

    modport slave (
        input  if_pc_i,
        input  ex_branch_i,
        input  ex_predict_taken_i,
        input  ex_taken_i,
        input  ex_pc_i,
        input  ex_pc_otherwise_i,
        output if_predict_taken_o,
        output flush_o,
        output pc_redirect_o,
        output branch_cnt_o,
        output mispredict_cnt_o
    );
endinterface

// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
// Dynamic branch predictor (table of 2-bit saturating counters indexed by
// PC[IDX_W+1:2]) plus EX-stage resolver: trains the table, flags
// mispredictions and keeps saturating branch/mispredict statistics.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-low reset
//   bus    branch_predict_unit_if.slave (lookup, EX fields, flush, stats)
// ----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter logic [1:0]  INIT_STATE  = 2'b10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_predict_unit_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_mis;
    logic [1:0]       w_ex_cnt;
    logic [1:0]       w_ex_cnt_next;
    logic             w_unused_pc_bits;

    assign w_if_idx = bus.if_pc_i[IDX_W+1:2];
    assign w_ex_idx = bus.ex_pc_i[IDX_W+1:2];

    // Only the index bits of either PC select an entry; no tag check.
    assign w_unused_pc_bits = ^{bus.if_pc_i[31:IDX_W+2], bus.if_pc_i[1:0],
                                bus.ex_pc_i[31:IDX_W+2], bus.ex_pc_i[1:0]};

    // Lookup reads the registered table: a same-cycle update is not bypassed.
    assign bus.if_predict_taken_o = r_bht[w_if_idx][1];

    assign w_mis         = bus.ex_branch_i & (bus.ex_taken_i != bus.ex_predict_taken_i);
    assign bus.flush_o   = w_mis & rst_i;
    assign bus.pc_redirect_o = bus.ex_pc_otherwise_i;

    assign bus.branch_cnt_o     = r_branch_cnt;
    assign bus.mispredict_cnt_o = r_mispredict_cnt;

    assign w_ex_cnt = r_bht[w_ex_idx];

    always_comb begin
        w_ex_cnt_next = w_ex_cnt;
        if (bus.ex_taken_i) begin
            if (w_ex_cnt != 2'b11) w_ex_cnt_next = w_ex_cnt + 2'b01;
        end else begin
            if (w_ex_cnt != 2'b00) w_ex_cnt_next = w_ex_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_bht[i] <= INIT_STATE;
            end
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (bus.ex_branch_i) begin
            r_bht[w_ex_idx] <= w_ex_cnt_next;
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mis && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.CNT_W(32)) bus  ();
    branch_predict_unit_if #(.CNT_W(4))  bus4 ();

    // Second instance with narrow statistics sees identical stimulus.
    assign bus4.if_pc_i            = bus.if_pc_i;
    assign bus4.ex_branch_i        = bus.ex_branch_i;
    assign bus4.ex_predict_taken_i = bus.ex_predict_taken_i;
    assign bus4.ex_taken_i         = bus.ex_taken_i;
    assign bus4.ex_pc_i            = bus.ex_pc_i;
    assign bus4.ex_pc_otherwise_i  = bus.ex_pc_otherwise_i;

    branch_predict_unit #(.BHT_ENTRIES(16), .INIT_STATE(2'b10), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    branch_predict_unit #(.BHT_ENTRIES(16), .INIT_STATE(2'b10), .CNT_W(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counter values as plain integers 0..3.
    int          m_bht [16];
    int unsigned m_br, m_mis, m_br4, m_mis4;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_bht[m_idx(pc)] >= 2;
    endfunction

    function automatic logic m_flush();
        return rst_n && bus.ex_branch_i && (bus.ex_taken_i != bus.ex_predict_taken_i);
    endfunction

    task automatic model_edge();
        int k;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 2;
            m_br = 0; m_mis = 0; m_br4 = 0; m_mis4 = 0;
        end else if (bus.ex_branch_i) begin
            k = m_idx(bus.ex_pc_i);
            if (bus.ex_taken_i) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
            else                m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (m_br4 != 15) m_br4++;
            if (bus.ex_taken_i != bus.ex_predict_taken_i) begin
                if (m_mis != 32'hFFFF_FFFF) m_mis++;
                if (m_mis4 != 15) m_mis4++;
            end
        end
    endtask

    task automatic drive(input logic br, input logic pred, input logic taken,
                         input logic [31:0] expc, input logic [31:0] other,
                         input logic [31:0] ifpc);
        bus.ex_branch_i        = br;
        bus.ex_predict_taken_i = pred;
        bus.ex_taken_i         = taken;
        bus.ex_pc_i            = expc;
        bus.ex_pc_otherwise_i  = other;
        bus.if_pc_i            = ifpc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h80, 32'h40);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.flush_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got %b want 0", bus.flush_o);
            end
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.branch_cnt_o !== 32'd0 || bus.mispredict_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.branch_cnt_o,
                     bus.mispredict_cnt_o);
        end
        for (int i = 0; i < 16; i++) begin
            bus.if_pc_i = $urandom & 32'hFFFF_FFC3 | (32'(i) << 2);
            #1;
            checks++;
            if (bus.if_predict_taken_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_predict pc %h got %b want 1", bus.if_pc_i,
                         bus.if_predict_taken_o);
            end
        end
    endtask

    task automatic test_saturation();
        // Expected prediction for pc 0x40 after each not-taken, then two takens.
        logic exp_pred [6];
        logic taken_seq [6];
        exp_pred  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        taken_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, m_pred(32'h40), taken_seq[s], 32'h40, 32'h0, 32'h40);
            tick();
            bus.ex_branch_i = 1'b0;
            #1;
            checks++;
            if (bus.if_predict_taken_o !== exp_pred[s]) begin
                errors++;
                $display("FAIL saturation step %0d got %b want %b", s,
                         bus.if_predict_taken_o, exp_pred[s]);
            end
        end
    endtask

    task automatic test_mispredict();
        drive(1'b1, 1'b0, 1'b1, 32'h208, 32'h80, 32'h0);
        #1;
        checks++;
        if (bus.flush_o !== 1'b1 || bus.pc_redirect_o !== 32'h80) begin
            errors++;
            $display("FAIL mispredict got flush %b pc %h want 1 00000080", bus.flush_o,
                     bus.pc_redirect_o);
        end
        tick();
        bus.ex_branch_i = 1'b0;
        checks++;
        if (bus.mispredict_cnt_o !== m_mis || bus.branch_cnt_o !== m_br) begin
            errors++;
            $display("FAIL mispredict_cnt got %0d/%0d want %0d/%0d", bus.branch_cnt_o,
                     bus.mispredict_cnt_o, m_br, m_mis);
        end
    endtask

    task automatic test_correct();
        int unsigned mis_before;
        mis_before = m_mis;
        drive(1'b1, 1'b1, 1'b1, 32'h20C, 32'h300, 32'h0);
        #1;
        checks++;
        if (bus.flush_o !== 1'b0) begin
            errors++;
            $display("FAIL correct_flush got %b want 0", bus.flush_o);
        end
        tick();
        bus.ex_branch_i = 1'b0;
        checks++;
        if (bus.branch_cnt_o !== m_br || bus.mispredict_cnt_o !== mis_before) begin
            errors++;
            $display("FAIL correct_cnt got %0d/%0d want %0d/%0d", bus.branch_cnt_o,
                     bus.mispredict_cnt_o, m_br, mis_before);
        end
    endtask

    task automatic test_collision();
        // Steer entry 1 to weakly-not-taken first.
        while (m_bht[1] != 1) begin
            drive(1'b1, 1'b0, (m_bht[1] < 1), 32'h44, 32'h0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 32'h104);
        #1;
        checks++;
        if (bus.if_predict_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_same got %b want 0", bus.if_predict_taken_o);
        end
        tick();
        bus.ex_branch_i = 1'b0;
        #1;
        checks++;
        if (bus.if_predict_taken_o !== 1'b1) begin
            errors++;
            $display("FAIL collision_next got %b want 1", bus.if_predict_taken_o);
        end
    endtask

    task automatic test_stat_saturation();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 17; n++) begin
            drive(1'b1, 1'b1, 1'b0, 32'($urandom), 32'h0, 32'h0);
            tick();
        end
        bus.ex_branch_i = 1'b0;
        checks++;
        if (bus4.branch_cnt_o !== 4'hF || bus4.mispredict_cnt_o !== 4'hF) begin
            errors++;
            $display("FAIL stat_saturation got %h/%h want f/f", bus4.branch_cnt_o,
                     bus4.mispredict_cnt_o);
        end
        checks++;
        if (bus.branch_cnt_o !== 32'd17 || bus.mispredict_cnt_o !== 32'd17) begin
            errors++;
            $display("FAIL stat_wide got %0d/%0d want 17/17", bus.branch_cnt_o,
                     bus.mispredict_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pcs [4];
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 4; j++) pcs[j] = $urandom;
            // Mix reused and fresh PCs to exercise aliasing and collisions.
            rst_n = !((n == 150) || ($urandom_range(0, 49) == 0));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  pcs[$urandom_range(0, 3)] & 32'h0000_007F, pcs[1],
                  ($urandom_range(0, 1) != 0) ? (pcs[0] & 32'h7F) : pcs[2]);
            #1;
            checks++;
            if (bus.flush_o !== m_flush() || bus.pc_redirect_o !== bus.ex_pc_otherwise_i
                || bus.if_predict_taken_o !== m_pred(bus.if_pc_i)) begin
                errors++;
                $display("FAIL random_comb n=%0d got fl %b pc %h pr %b want %b %h %b", n,
                         bus.flush_o, bus.pc_redirect_o, bus.if_predict_taken_o, m_flush(),
                         bus.ex_pc_otherwise_i, m_pred(bus.if_pc_i));
            end
            tick();
            checks++;
            if (bus.branch_cnt_o !== m_br || bus.mispredict_cnt_o !== m_mis
                || bus4.branch_cnt_o !== 4'(m_br4) || bus4.mispredict_cnt_o !== 4'(m_mis4))
            begin
                errors++;
                $display("FAIL random_cnt n=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", n,
                         bus.branch_cnt_o, bus.mispredict_cnt_o, bus4.branch_cnt_o,
                         bus4.mispredict_cnt_o, m_br, m_mis, m_br4, m_mis4);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_bht[i] = 2;
        m_br = 0; m_mis = 0; m_br4 = 0; m_mis4 = 0;
        test_reset();
        test_saturation();
        test_mispredict();
        test_correct();
        test_collision();
        test_stat_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
